// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous-read instruction memory with run-time program load,
// registered fetch port and post-reset clear sweep. Define IMEM_PARITY_EN for per-word even parity.
//   state | meaning
//   SWEEP | writing NOP_WORD to every word after reset; fetch and load are ignored
//   RUN   | normal fetch and program-load operation
module instr_mem_sync #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 10,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Address,
  input  logic              ReadEn,
  input  logic              Stall,
  output logic [DATA_W-1:0] Instruction,
  output logic              InstrValid,
  output logic              AddrFault,
  input  logic              LoadEn,
  input  logic [31:0]       LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic              LoadAck,
  output logic              LoadFault,
  output logic              Ready,
  output logic              ParityErr,
  input  logic              ParityInj
);

  localparam int               IDX_W    = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sweep_we;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  fetch_idx, load_idx;
  logic              fetch_ok, load_ok, load_we;
  logic [DATA_W-1:0] rd_word;
  logic              par_bad;
  logic              unused_bits;

  // Bit 31 is the kernel-segment bit and never takes part in the decode.
  function automatic logic addr_ok(input logic [30:0] a);
    logic [31:0] idx_ext;
    idx_ext = 32'(a[ADDR_W-1:2]);
    return (a[1:0] == 2'b00) && (a[30:ADDR_W] == '0) && (idx_ext < 32'(DEPTH));
  endfunction

  assign fetch_idx = Address[ADDR_W-1:2];
  assign load_idx  = LoadAddr[ADDR_W-1:2];
  assign fetch_ok  = addr_ok(Address[30:0]);
  assign load_ok   = addr_ok(LoadAddr[30:0]);
  assign load_we   = (state_q == RUN) && LoadEn && load_ok;
  assign rd_word   = mem[fetch_idx];
  assign Ready     = (state_q == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) state_d = RUN;
      end
      RUN: ;
      default: state_d = SWEEP;
    endcase
  end

  // Storage has no reset; the sweep is the only clearing path.
  always_ff @(posedge clk) begin
    if (sweep_we)     mem[cnt_q]    <= NOP_WORD;
    else if (load_we) mem[load_idx] <= LoadData;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (sweep_we)     par_mem[cnt_q]    <= ^NOP_WORD;
    else if (load_we) par_mem[load_idx] <= (^LoadData) ^ ParityInj;
  end

  assign par_bad     = (^rd_word) ^ par_mem[fetch_idx];
  assign unused_bits = ^{Address[31], LoadAddr[31]};
`else
  assign par_bad     = 1'b0;
  assign unused_bits = ^{Address[31], LoadAddr[31], ParityInj};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instruction <= NOP_WORD;
      InstrValid  <= 1'b0;
      AddrFault   <= 1'b0;
      ParityErr   <= 1'b0;
      LoadAck     <= 1'b0;
      LoadFault   <= 1'b0;
    end else if (state_q != RUN) begin
      InstrValid  <= 1'b0;
      AddrFault   <= 1'b0;
      ParityErr   <= 1'b0;
      LoadAck     <= 1'b0;
      LoadFault   <= 1'b0;
    end else begin
      LoadAck   <= LoadEn;
      LoadFault <= LoadEn && !load_ok;
      if (!Stall) begin
        if (ReadEn && !LoadEn) begin
          InstrValid  <= 1'b1;
          AddrFault   <= !fetch_ok;
          ParityErr   <= fetch_ok && par_bad;
          Instruction <= (fetch_ok && !par_bad) ? rd_word : NOP_WORD;
        end else begin
          // A fetch colliding with a load is dropped; the core retries it.
          InstrValid  <= 1'b0;
          AddrFault   <= 1'b0;
          ParityErr   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined MIPS core; successor to the hard-coded combinational instruction ROM.
- Instruction words are loaded at run time through a program-load port (e.g. a UART boot loader), so the image is no longer fixed in RTL.
- Provides a registered fetch port with stall hold, address-fault detection and a post-reset clear sweep.

Parameters:
- DATA_W, 32, instruction word width.
- DEPTH, 256, number of words; must satisfy DEPTH <= 2^(ADDR_W-2).
- ADDR_W, 10, byte-address bits used for indexing; word index = Address[ADDR_W-1:2].
- NOP_WORD, 32'h00000000, word written by the sweep and returned on faults.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  fetch byte address (PC). Bit 31 (kernel bit) is ignored.
- ReadEn  in  1  fetch request.
- Stall  in  1  pipeline stall; fetch outputs hold while high.
- Instruction  out  DATA_W  registered fetched word.
- InstrValid  out  1  Instruction is valid for this cycle.
- AddrFault  out  1  registered alongside Instruction; set when the fetch address was illegal.
- LoadEn  in  1  program-load write strobe.
- LoadAddr  in  32  load byte address; same decode as Address.
- LoadData  in  DATA_W  word to write.
- LoadAck  out  1  one-cycle acknowledge of a load.
- LoadFault  out  1  one-cycle pulse with LoadAck when the load address was illegal.
- Ready  out  1  high once the clear sweep has finished.
- ParityErr  out  1  parity mismatch on fetch; tied 0 without the optional feature.
- ParityInj  in  1  parity-error injection; used only with the optional feature.

Behaviour:
- Asynchronous reset (reset=0):
  - Outputs: Instruction=NOP_WORD; InstrValid, AddrFault, LoadAck, LoadFault, Ready and ParityErr all 0.
  - State=SWEEP, sweep counter=0.
  - Reset asserted at any time, including mid-sweep or mid-run, restarts the sweep from word 0.
- Address legality: legal iff Address[1:0]==0, Address[30:ADDR_W]==0 and index < DEPTH. Otherwise it is a fault.
- SWEEP state:
  - Each cycle writes NOP_WORD to mem[cnt] and increments cnt.
  - After writing cnt==DEPTH-1, transitions to RUN. Ready=1 from the first RUN cycle, i.e. DEPTH cycles after reset release.
  - ReadEn and LoadEn are ignored; InstrValid and LoadAck stay 0.
- RUN state, fetch path, evaluated at each rising edge in priority order:
  1. Stall=1: Instruction, InstrValid, AddrFault and ParityErr hold their values.
  2. LoadEn=1 with ReadEn=1: the fetch is dropped; InstrValid<=0 and Instruction holds. The core must retry.
  3. ReadEn=1: Instruction<=mem[index] (NOP_WORD on fault), InstrValid<=1, AddrFault<=fault. Latency is 1 cycle.
  4. ReadEn=0: InstrValid<=0 and AddrFault<=0; Instruction holds.
- RUN state, load path (independent of Stall):
  - With LoadEn=1, legal LoadAddr writes LoadData at the edge.
  - The next cycle LoadAck=1 for exactly one cycle; LoadFault=1 with it if the address was illegal (no write in that case).
  - Back-to-back LoadEn each gets its own ack.
- Read-after-write: a fetch issued the cycle after a load to the same address returns the new data.
- Memory is never reset directly; the sweep is the only clearing mechanism.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed on sweep and load writes.
  - When ParityInj=1 during a load, the stored parity bit is inverted.
  - On a fetch whose parity mismatches: ParityErr<=1, Instruction<=NOP_WORD, InstrValid<=1.
  - ParityErr follows the same hold and clear rules as AddrFault.
- Undefined: no parity storage; ParityErr is constant 0; ParityInj is ignored.

Test Plan:
1. Reset release with DEPTH=256 -> Ready=0 for 256 cycles and 1 on the next. A fetch of 0x00000040 -> Instruction=0x00000000, InstrValid=1, AddrFault=0.
2. Load 0x08000010 at LoadAddr 0x0 -> LoadAck=1 next cycle, LoadFault=0. Then fetch 0x00000000 and 0x80000000 -> both return 0x08000010 one cycle after ReadEn.
3. Fetch 0x00000400 (index 256) -> AddrFault=1, Instruction=0. Fetch 0x00000006 -> AddrFault=1. Load to 0x00000402 -> LoadAck=1 and LoadFault=1, with no memory change.
4. Fetch word 5 (0x00000014, containing 0x3C0D4000), then Stall=1 for 3 cycles while Address changes -> Instruction stays 0x3C0D4000 with InstrValid=1 throughout.
5. LoadEn and ReadEn in the same cycle at address 0x8 with data 0xAD000008 -> InstrValid=0 next cycle and LoadAck=1; the retried fetch returns 0xAD000008.
6. Assert reset at sweep count 100 -> Ready stays 0 for a full 256 cycles after release and previously loaded words read 0. With IMEM_PARITY_EN: load with ParityInj=1, then fetch -> ParityErr=1, Instruction=0.
